// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-word SRAM controller between two requesters.
// Port 0 is the MEM stage, port 1 a secondary master (fetch/loader). A
// round-robin grant is taken in IDLE. The winner's operation, address and write
// data are latched and driven to the controller until it reports completion.
// The enables are then held for TAIL_CYCLES more cycles so the controller's
// internal sequence returns to its start state.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   reqN_rd_en, reqN_wr_en   port N read/write request (write wins if both)
//   reqN_addr, reqN_wdata    port N byte address / write data
//   reqN_rdata               port N read data (mem_rdata passthrough on completion)
//   reqN_freeze              port N stall, combinational
//   mem_rd_en, mem_wr_en     controller enables (registered)
//   mem_addr, mem_wdata      controller address / write data (registered)
//   mem_rdata, mem_freeze    controller read data / busy
module sram_arbiter #(
    parameter int unsigned TAIL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_rd_en,
    input  logic        req0_wr_en,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic [31:0] req0_rdata,
    output logic        req0_freeze,
    input  logic        req1_rd_en,
    input  logic        req1_wr_en,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic [31:0] req1_rdata,
    output logic        req1_freeze,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_freeze
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAIL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_gnt_q, last_gnt_d;
    logic                op_wr_q, op_wr_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;

    logic active0, active1;
    logic win, win_wr;
    logic done_c;

    assign active0 = req0_rd_en | req0_wr_en;
    assign active1 = req1_rd_en | req1_wr_en;

    // Completion cycle of the granted transaction.
    assign done_c = (state_q == BUSY) & ~mem_freeze;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tail_cnt_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tail_cnt_q <= tail_cnt_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
        end
    end

    // Arbitration, sequencing and next-value logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tail_cnt_d = tail_cnt_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rd_en_d    = rd_en_q;
        wr_en_d    = wr_en_q;
        win        = 1'b0;
        win_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (active0 | active1) begin
                    // On a tie the port that did not win last time goes next.
                    win        = (active0 & active1) ? ~last_gnt_q : active1;
                    win_wr     = win ? req1_wr_en : req0_wr_en;
                    gnt_d      = win;
                    last_gnt_d = win;
                    op_wr_d    = win_wr;
                    addr_d     = win ? req1_addr  : req0_addr;
                    wdata_d    = win ? req1_wdata : req0_wdata;
                    rd_en_d    = ~win_wr;
                    wr_en_d    = win_wr;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (!mem_freeze) begin
                    // Read data is captured even if the requester has dropped out.
                    if (!op_wr_q) begin
                        if (gnt_q) begin
                            rdata1_d = mem_rdata;
                        end else begin
                            rdata0_d = mem_rdata;
                        end
                    end
                    if (TAIL_CYCLES == 0) begin
                        state_d = IDLE;
                        rd_en_d = 1'b0;
                        wr_en_d = 1'b0;
                    end else begin
                        state_d    = TAIL;
                        tail_cnt_d = TAIL_W'(TAIL_CYCLES);
                    end
                end
            end
            TAIL: begin
                // Enables stay up so the controller can unwind its sequence.
                tail_cnt_d = tail_cnt_q - TAIL_W'(1);
                if (tail_cnt_q <= TAIL_W'(1)) begin
                    state_d = IDLE;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Freeze drops only in the owner's completion cycle.
    assign req0_freeze = active0 & ~(done_c & ~gnt_q);
    assign req1_freeze = active1 & ~(done_c &  gnt_q);

    assign req0_rdata = (done_c & ~gnt_q & ~op_wr_q) ? mem_rdata : rdata0_q;
    assign req1_rdata = (done_c &  gnt_q & ~op_wr_q) ? mem_rdata : rdata1_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single-word SRAM controller between two pipeline requesters: port 0 is the MEM stage and port 1 is a secondary master such as instruction fetch or a loader. It registers a round-robin grant and latches the winner's operation, address and write data. It drives the controller until the controller reports completion, then holds the operation for a fixed tail so the controller's internal sequence returns to its start state. Each requester sees a freeze signal that stays high until its own transaction completes.

## Interface
- TAIL_CYCLES, 1: cycles the mem enable stays asserted after the completion cycle (range 0–7).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_rd_en, req0_wr_en  in  1 each  port-0 read/write request; held until req0_freeze is low.
- req0_addr  in  32  port-0 byte address.
- req0_wdata  in  32  port-0 write data.
- req0_rdata  out  32  port-0 read data.
- req0_freeze  out  1  port-0 stall.
- req1_rd_en, req1_wr_en, req1_addr, req1_wdata, req1_rdata, req1_freeze: same as port 0, for port 1.
- mem_rd_en, mem_wr_en  out  1 each  to the SRAM controller.
- mem_addr, mem_wdata  out  32 each  to the SRAM controller.
- mem_rdata  in  32  controller read data register.
- mem_freeze  in  1  controller busy; low while an enable is high marks the completion cycle.

## Operation
- reqN_active = reqN_rd_en | reqN_wr_en.
- If both enables of one port are high, the request is a write.
- State machine states: IDLE, BUSY, TAIL. Registers: gnt (1 bit), last_gnt (1 bit), op_wr, addr_q, wdata_q, tail_cnt (3 bits), rdata0_q, rdata1_q.
- IDLE
  - No request active: stay in IDLE; mem enables low.
  - Only one port active: grant that port.
  - Both ports active: grant the port that is not last_gnt (round-robin).
  - On grant: gnt and last_gnt are set to the winner; op_wr, addr_q and wdata_q latch the winner's inputs; next state is BUSY.
- BUSY
  - mem_rd_en = ~op_wr and mem_wr_en = op_wr; mem_addr = addr_q; mem_wdata = wdata_q.
  - Completion cycle (mem_freeze low): if ~op_wr, rdata{gnt}_q <= mem_rdata.
  - After completion: go to TAIL with tail_cnt = TAIL_CYCLES, or to IDLE if TAIL_CYCLES = 0.
- TAIL
  - mem outputs are unchanged from BUSY.
  - tail_cnt decrements each cycle; when it reaches 1, next state is IDLE.
  - Requester inputs are ignored.
- The latched transaction always runs to completion, even if its requester drops its enables (flush); the result is still written to rdataN_q.
- reqN_freeze is combinational: reqN_active & ~(state==BUSY & gnt==N & ~mem_freeze).
- reqN_rdata: in the completion cycle with gnt==N and a read, it passes mem_rdata through; otherwise it shows rdataN_q.

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE, last_gnt = 1 so port 0 wins the first tie, gnt = 0.
  - addr_q, wdata_q, rdata0_q, rdata1_q = 0; tail_cnt = 0.
  - mem_rd_en, mem_wr_en = 0; mem_addr, mem_wdata = 0.
  - reqN_freeze = reqN_active during reset.
- Reset asserted mid-transaction: abort immediately to IDLE, mem enables drop, no rdata update. The controller is reset by the same rst.
- Arbitration latency: a request seen in IDLE at cycle t drives the mem enable from cycle t+1.
- Service time: the controller's busy time plus TAIL_CYCLES plus 1 IDLE cycle before the next grant.
- Requester handshake: the requester samples reqN_rdata and advances at the edge where reqN_freeze is low. In that cycle the data is already valid.
- A non-granted active port keeps freeze high for the whole BUSY, TAIL and IDLE turnaround.
- Back-to-back requests from the same port while the other port is waiting: the grant alternates.

## Test plan
- Single read: port 0 reads addr 0x40, mem_freeze high for 4 cycles then low, mem_rdata 0xDEADBEEF -> mem_rd_en from cycle 1; req0_freeze low exactly in the completion cycle; req0_rdata = 0xDEADBEEF; mem_rd_en stays high 1 more cycle (TAIL_CYCLES = 1) then drops.
- Simultaneous first requests: port 0 writes 0x11223344 to 0x10 while port 1 reads 0x20 -> port 0 is granted first with mem_wdata 0x11223344 and req1_freeze held high; port 1 is granted after TAIL plus 1 IDLE cycle with mem_addr 0x20.
- Round-robin: both ports request continuously for 4 transactions -> grant sequence 0,1,0,1.
- Flush mid-op: port 1 drops req1_rd_en during BUSY -> the transaction still completes, rdata1_q updates, req1_freeze is low after the drop.
- Rd and wr both asserted on port 0 -> mem_wr_en = 1, mem_rd_en = 0.
- Async reset asserted in BUSY between clock edges -> mem enables go to 0 immediately, state is IDLE, the next request is granted to port 0.
